// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, start-bit glitch rejection and
// stop-bit framing check. Everything runs on clk; reset is synchronous, active-low.
//
// state | meaning
// IDLE  | waiting for a high-to-low edge on rx_s
// START | checking the start bit at mid-bit (sample 7)
// DATA  | shifting in 8 data bits, LSB first, one per 16 ticks
// STOP  | sampling the stop bit, then flagging valid or frame error
module uart_rx #(
  parameter int system_clock = 25000000,
  parameter int rx_baudrate  = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int TICK_MAX = system_clock / (16 * rx_baudrate);
  localparam int TICK_W   = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state;
  logic              rx_m;
  logic              rx_s;
  logic              rx_prev;
  logic [TICK_W-1:0] tick_cnt;
  logic [3:0]        sample_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic              tick;
  logic              start_edge;

  assign tick       = (tick_cnt == TICK_LAST);
  assign start_edge = rx_prev & ~rx_s;

  // Two-flop synchronizer plus one more stage for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rx_in;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      sample_cnt   <= 4'd0;
      bit_idx      <= 3'd0;
      shift_reg    <= 8'h00;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      tick_cnt     <= tick ? '0 : tick_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start_edge) begin
            // Realign the oversample grid to the falling edge of the start bit.
            tick_cnt   <= '0;
            sample_cnt <= 4'd0;
            bit_idx    <= 3'd0;
            state      <= START;
            rx_busy    <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            if (sample_cnt == 4'd7) begin
              sample_cnt <= 4'd0;
              if (!rx_s) begin
                state <= DATA;
              end else begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              sample_cnt <= sample_cnt + 4'd1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 4'd1;
            if (sample_cnt == 4'd15) begin
              shift_reg <= {rx_s, shift_reg[7:1]};
              bit_idx   <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
                state <= STOP;
              end
            end
          end
        end

        STOP: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 4'd1;
            if (sample_cnt == 4'd15) begin
              // Leave at mid stop bit so a back-to-back start edge is not missed.
              if (rx_s) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
              end else begin
                rx_frame_err <= 1'b1;
              end
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end
        end

        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
